// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
//   arb_state_t : transaction sequencer states
//   req_id_t    : requester identity (data/TLB side vs instruction-cache side)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_TLB = 1'b0,
    REQ_IC  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick, purely combinational.
//   req[0]      : data-side (TLB) request
//   req[1]      : instruction-side request
//   last_grant  : side granted most recently
//   grant_id    : chosen side (valid only when grant_valid)
//   grant_valid : at least one request present
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output req_id_t    grant_id,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_TLB;
    unique case (req)
      2'b10:   grant_id = REQ_IC;
      // On a tie the side that did not win last time goes first.
      2'b11:   grant_id = (last_grant == REQ_TLB) ? REQ_IC : REQ_TLB;
      default: grant_id = REQ_TLB;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the data-side (TLB/tag miss) path and
// the instruction-cache miss path. Round-robin grant in IDLE, a fixed
// mem_latency-cycle BUSY phase, then a one-cycle DONE with serviceReady to
// the winner.
//   clk, reset            : clock, asynchronous active-low reset
//   *TlbArb / *ArbTlb     : data-side request, address, write, line, pulse, fill
//   *IcArb / *ArbIc       : instruction-side request, address, pulse, fill
//   memReq/Addr/We/Wdata  : memory transaction, stable through BUSY
//   memRdata              : memory read line, valid in the last BUSY cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned cache_line_width = 256,
  parameter int unsigned addr_width       = 16,
  parameter int unsigned offset_bits      = 5,
  parameter int unsigned mem_latency      = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        petitionTlbArb,
  input  logic [addr_width-1:0]       addrTlbArb,
  input  logic                        weTlbArb,
  input  logic [cache_line_width-1:0] wdataTlbArb,
  output logic                        serviceReadyArbTlb,
  output logic [cache_line_width-1:0] rdataArbTlb,
  input  logic                        petitionIcArb,
  input  logic [addr_width-1:0]       addrIcArb,
  output logic                        serviceReadyArbIc,
  output logic [cache_line_width-1:0] rdataArbIc,
  output logic                        memReq,
  output logic [addr_width-1:0]       memAddr,
  output logic                        memWe,
  output logic [cache_line_width-1:0] memWdata,
  input  logic [cache_line_width-1:0] memRdata
);

  localparam int unsigned CNT_W = $clog2(mem_latency) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(mem_latency - 1);
  localparam logic [addr_width-1:0] LINE_MASK =
    {{(addr_width - offset_bits){1'b1}}, {offset_bits{1'b0}}};

  arb_state_t       state, state_nxt;
  req_id_t          last_grant;
  req_id_t          grant_id;
  req_id_t          pick_id;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;
  logic             last_beat;
  logic             grant_now;

  rr_arb2 u_rr_arb2 (
    .req         ({petitionIcArb, petitionTlbArb}),
    .last_grant  (last_grant),
    .grant_id    (pick_id),
    .grant_valid (pick_valid)
  );

  assign last_beat = (state == BUSY) && (cnt == CNT_LAST);
  assign grant_now = (state == IDLE) && pick_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    memReq             = 1'b0;
    serviceReadyArbTlb = 1'b0;
    serviceReadyArbIc  = 1'b0;
    unique case (state)
      IDLE: if (pick_valid) state_nxt = BUSY;
      BUSY: begin
        memReq = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        serviceReadyArbTlb = (grant_id == REQ_TLB);
        serviceReadyArbIc  = (grant_id == REQ_IC);
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requester inputs are captured only at grant; BUSY/DONE ignore them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant  <= REQ_IC;
      grant_id    <= REQ_TLB;
      cnt         <= '0;
      memAddr     <= '0;
      memWe       <= 1'b0;
      memWdata    <= '0;
      rdataArbTlb <= '0;
      rdataArbIc  <= '0;
    end else begin
      if (grant_now) begin
        grant_id   <= pick_id;
        last_grant <= pick_id;
        cnt        <= '0;
        if (pick_id == REQ_TLB) begin
          memAddr  <= addrTlbArb & LINE_MASK;
          memWe    <= weTlbArb;
          memWdata <= wdataTlbArb;
        end else begin
          memAddr  <= addrIcArb & LINE_MASK;
          memWe    <= 1'b0;
          memWdata <= '0;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (last_beat && !memWe) begin
        if (grant_id == REQ_TLB) rdataArbTlb <= memRdata;
        else                     rdataArbIc  <= memRdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LW  = 256;
  localparam int AW  = 16;
  localparam int LAT = 10;

  logic          clk;
  logic          reset;
  logic          petitionTlbArb, weTlbArb, petitionIcArb;
  logic [AW-1:0] addrTlbArb, addrIcArb;
  logic [LW-1:0] wdataTlbArb, memRdata;
  logic          serviceReadyArbTlb, serviceReadyArbIc, memReq, memWe;
  logic [LW-1:0] rdataArbTlb, rdataArbIc, memWdata;
  logic [AW-1:0] memAddr;

  mem_arbiter #(
    .cache_line_width (LW),
    .addr_width       (AW),
    .offset_bits      (5),
    .mem_latency      (LAT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .petitionTlbArb     (petitionTlbArb),
    .addrTlbArb         (addrTlbArb),
    .weTlbArb           (weTlbArb),
    .wdataTlbArb        (wdataTlbArb),
    .serviceReadyArbTlb (serviceReadyArbTlb),
    .rdataArbTlb        (rdataArbTlb),
    .petitionIcArb      (petitionIcArb),
    .addrIcArb          (addrIcArb),
    .serviceReadyArbIc  (serviceReadyArbIc),
    .rdataArbIc         (rdataArbIc),
    .memReq             (memReq),
    .memAddr            (memAddr),
    .memWe              (memWe),
    .memWdata           (memWdata),
    .memRdata           (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a transaction is "active" for LAT+1 cycles after grant;
  // m_t counts elapsed cycles (1..LAT on the memory, LAT+1 = completion).
  bit            m_active;
  int            m_t;
  bit            m_owner;   // 0 = data side, 1 = instruction side
  bit            m_prefer;  // side that wins the next tie
  logic [AW-1:0] m_addr;
  bit            m_we;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rd [2];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd256();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_t = 0; m_owner = 0; m_prefer = 0;
    m_addr = '0; m_we = 0; m_wdata = '0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  function automatic bit exp_req();
    return m_active && (m_t <= LAT);
  endfunction

  function automatic bit exp_pulse(input bit side);
    return m_active && (m_t == LAT + 1) && (m_owner == side);
  endfunction

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    logic [AW-1:0] a;
    if (!reset) begin
      model_reset();
    end else if (!m_active) begin
      if (petitionTlbArb || petitionIcArb) begin
        if (petitionTlbArb && petitionIcArb) m_owner = m_prefer;
        else                                 m_owner = petitionIcArb;
        m_prefer = !m_owner;
        a        = m_owner ? addrIcArb : addrTlbArb;
        m_addr   = AW'((int'(a) / 32) * 32);
        m_we     = !m_owner && weTlbArb;
        m_wdata  = m_owner ? '0 : wdataTlbArb;
        m_active = 1;
        m_t      = 1;
      end
    end else if (m_t == LAT + 1) begin
      m_active = 0;
    end else begin
      if (m_t == LAT && !m_we) m_rd[m_owner] = memRdata;
      m_t++;
    end
  endtask

  task automatic check_all();
    chk("memReq", memReq, exp_req());
    if (exp_req()) begin
      chk("memAddr", memAddr, m_addr);
      chk("memWe", memWe, m_we);
      chk("memWdata", memWdata, m_wdata);
    end
    chk("srTlb", serviceReadyArbTlb, exp_pulse(0));
    chk("srIc", serviceReadyArbIc, exp_pulse(1));
    chk("rdataTlb", rdataArbTlb, m_rd[0]);
    chk("rdataIc", rdataArbIc, m_rd[1]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_pulse(input bit ic, output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      memRdata = rnd256();
      n = i + 1;
      if ((ic ? serviceReadyArbIc : serviceReadyArbTlb) === 1'b1) break;
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    petitionTlbArb = 0; petitionIcArb = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pc [3];
    int ps [3];
    int np;
    logic [LW-1:0] pat_a5, pat_5a;
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};

    reset = 0;
    petitionTlbArb = 0; addrTlbArb = '0; weTlbArb = 0; wdataTlbArb = '0;
    petitionIcArb = 0; addrIcArb = '0; memRdata = '0;
    model_reset();
    cycle();
    cycle();
    chk("reset_memAddr", memAddr, '0);
    chk("reset_memReq", memReq, 1'b0);
    reset = 1'b1;

    // Data-side read, latency 11.
    petitionTlbArb = 1; addrTlbArb = 16'h1234; weTlbArb = 0;
    for (int c = 1; c <= 11; c++) begin
      cycle();
      if (c <= 10) begin
        chk("rd_memReq", memReq, 1'b1);
        chk("rd_memAddr", memAddr, 16'h1220);
      end
      chk("rd_srTlb", serviceReadyArbTlb, (c == 11));
      chk("rd_srIc", serviceReadyArbIc, 1'b0);
      if (c == 11) chk("rd_rdataTlb", rdataArbTlb, pat_a5);
      memRdata = (c == 10) ? pat_a5 : rnd256();
    end
    petitionTlbArb = 0;

    // Data-side write: rdata untouched, pulse still at 11.
    cycle();
    chk("wr_idle_memReq", memReq, 1'b0);
    petitionTlbArb = 1; weTlbArb = 1; wdataTlbArb = pat_5a; addrTlbArb = 16'h0BEF;
    for (int c = 1; c <= 11; c++) begin
      cycle();
      if (c <= 10) begin
        chk("wr_memWe", memWe, 1'b1);
        chk("wr_memWdata", memWdata, pat_5a);
        chk("wr_memAddr", memAddr, 16'h0BE0);
      end
      chk("wr_srTlb", serviceReadyArbTlb, (c == 11));
      if (c == 11) chk("wr_rdataTlb", rdataArbTlb, pat_a5);
      memRdata = rnd256();
    end

    // Back-to-back same side: drop after pulse, re-assert in the IDLE cycle.
    petitionTlbArb = 0;
    cycle();
    chk("b2b_idle_memReq", memReq, 1'b0);
    petitionTlbArb = 1; weTlbArb = 0; addrTlbArb = 16'h4321;
    cycle();
    chk("b2b_memReq", memReq, 1'b1);
    chk("b2b_memAddr", memAddr, 16'h4320);
    wait_pulse(0, n);
    chk("b2b_remaining", n, 10);
    petitionTlbArb = 0;

    // Contested rounds after reset: TLB, IC, TLB.
    do_reset();
    petitionTlbArb = 1; petitionIcArb = 1; weTlbArb = 0;
    addrTlbArb = AW'($urandom); addrIcArb = AW'($urandom);
    np = 0;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (serviceReadyArbTlb === 1'b1 && np < 3) begin pc[np] = c; ps[np] = 0; np++; end
      if (serviceReadyArbIc === 1'b1 && np < 3)  begin pc[np] = c; ps[np] = 1; np++; end
      if (exp_pulse(0)) petitionTlbArb = 0;
      else if (!petitionTlbArb) begin petitionTlbArb = 1; addrTlbArb = AW'($urandom); end
      if (exp_pulse(1)) petitionIcArb = 0;
      else if (!petitionIcArb) begin petitionIcArb = 1; addrIcArb = AW'($urandom); end
      memRdata = rnd256();
    end
    chk("rr_npulses", np, 3);
    if (np == 3) begin
      chk("rr_cyc0", pc[0], 11); chk("rr_side0", ps[0], 0);
      chk("rr_cyc1", pc[1], 23); chk("rr_side1", ps[1], 1);
      chk("rr_cyc2", pc[2], 35); chk("rr_side2", ps[2], 0);
    end

    // Instruction-side inputs change mid-transaction.
    do_reset();
    petitionIcArb = 1; addrIcArb = 16'h2A7C;
    for (int c = 1; c <= 11; c++) begin
      cycle();
      if (c <= 10) chk("mid_memAddr", memAddr, 16'h2A60);
      chk("mid_srIc", serviceReadyArbIc, (c == 11));
      if (c == 4) begin addrIcArb = 16'hFFFF; petitionIcArb = 0; end
      memRdata = rnd256();
    end

    // Asynchronous reset while BUSY, then full-latency re-grant.
    petitionTlbArb = 1; weTlbArb = 0; addrTlbArb = 16'h7777;
    repeat (5) cycle();
    chk("rst_pre_memReq", memReq, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_memReq", memReq, 1'b0);
    check_all();
    chk("rst_memAddr", memAddr, '0);
    chk("rst_memWe", memWe, 1'b0);
    chk("rst_memWdata", memWdata, '0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_hold_srTlb", serviceReadyArbTlb, 1'b0);
    end
    reset = 1'b1;
    wait_pulse(0, n);
    chk("rst_regrant_latency", n, 11);
    petitionTlbArb = 0;

    // Randomized traffic obeying the request/drop protocol.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      if (petitionTlbArb && exp_pulse(0)) petitionTlbArb = 0;
      else if (!petitionTlbArb && ($urandom % 4 == 0)) begin
        petitionTlbArb = 1; addrTlbArb = AW'($urandom);
        weTlbArb = $urandom % 2; wdataTlbArb = rnd256();
      end else if (petitionTlbArb && m_active && m_owner == 0 && ($urandom % 3 == 0)) begin
        addrTlbArb = AW'($urandom); weTlbArb = $urandom % 2; wdataTlbArb = rnd256();
      end
      if (petitionIcArb && exp_pulse(1)) petitionIcArb = 0;
      else if (!petitionIcArb && ($urandom % 4 == 0)) begin
        petitionIcArb = 1; addrIcArb = AW'($urandom);
      end else if (petitionIcArb && m_active && m_owner == 1 && ($urandom % 3 == 0)) begin
        addrIcArb = AW'($urandom);
      end
      memRdata = rnd256();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the data-side requester (TLB-lookup/tag miss path: petitionTlbArb/addrTlbArb/weTlbArb/serviceReadyArbTlb) and the instruction-cache miss path.
- Performs round-robin grant, latches the winner's request, and sequences a fixed-latency memory transaction.
- Returns the line and a one-cycle serviceReady pulse to the winner.
- Sits between both caches and the memory model.

Parameters:
- cache_line_width, 256, bits per line transferred per transaction
- addr_width, 16, byte address width
- offset_bits, 5, low address bits cleared to form the line address (log2 of line bytes)
- mem_latency, 10, memory cycles per transaction (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- petitionTlbArb  in  1  data-side request, held until serviceReadyArbTlb
- addrTlbArb  in  addr_width  data-side address
- weTlbArb  in  1  data-side write (1) / line fill (0)
- wdataTlbArb  in  cache_line_width  data-side line to write
- serviceReadyArbTlb  out  1  one-cycle completion pulse to data side
- rdataArbTlb  out  cache_line_width  fill line for data side
- petitionIcArb  in  1  instruction-side fill request, held until serviceReadyArbIc
- addrIcArb  in  addr_width  instruction-side address
- serviceReadyArbIc  out  1  one-cycle completion pulse to instruction side
- rdataArbIc  out  cache_line_width  fill line for instruction side
- memReq  out  1  memory transaction active
- memAddr  out  addr_width  line-aligned address (low offset_bits = 0)
- memWe  out  1  memory write
- memWdata  out  cache_line_width  write line
- memRdata  in  cache_line_width  read line, valid in the last BUSY cycle

Behaviour:
- States: IDLE, BUSY, DONE. Reset (reset=0, asynchronous):
  - state=IDLE, lastGrant=IC, so the data side wins the first tie.
  - counter=0.
  - All outputs 0, including rdata and the latched address/we/wdata.
- IDLE:
  - If any petition is high, select the winner at the edge.
    - One requester high: that requester wins.
    - Both high: the side not equal to lastGrant wins.
  - On grant, latch grantId, memAddr = addr & ~((1<<offset_bits)-1), memWe (always 0 for IC), and memWdata (0 for IC). Update lastGrant, set counter=0, go to BUSY.
  - No petition: stay in IDLE.
- BUSY:
  - memReq=1; memAddr, memWe and memWdata stay stable.
  - counter increments each cycle.
  - When counter == mem_latency-1:
    - If !memWe, capture memRdata into the granted side's rdata register.
    - Go to DONE.
- DONE:
  - memReq=0.
  - The granted side's serviceReady=1 for exactly this cycle; the other side's stays 0.
  - rdata is valid this cycle and holds until that side's next fill completes.
  - Next state is IDLE.
- Latency: petition first sampled high in IDLE at cycle 0 -> memReq high cycles 1..mem_latency -> serviceReady at cycle mem_latency+1. Default: cycle 11.
- Requester inputs are sampled only at grant. Address changes or petition drops during BUSY/DONE are ignored, and the transaction completes with its pulse.
- A petition seen in IDLE on the cycle after DONE is a new request. Requesters must drop petition on the edge after serviceReady.
- Writes leave rdataArbTlb unchanged; serviceReady still pulses.
- The losing requester waits; starvation is bounded to one transaction by round-robin.
- Reset mid-transaction: immediate return to IDLE, outputs cleared, no serviceReady pulse, no data captured.
- Counter width = clog2(mem_latency)+1. The counter never wraps; it is cleared on grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - requester IDs (REQ_TLB=1'b0, REQ_IC=1'b1)
- Sub-module rr_arb2: combinational two-input round-robin pick (req[1:0], lastGrant) -> grant id plus valid. The pointer register stays in mem_arbiter.

Test Plan:
- Data read only: petitionTlbArb=1, addrTlbArb=16'h1234, weTlbArb=0 at cycle 0. Required:
  - memAddr=16'h1220 and memReq=1 over cycles 1..10.
  - memRdata driven to 256'hA5.. at cycle 10.
  - serviceReadyArbTlb=1 only at cycle 11, rdataArbTlb=256'hA5..; serviceReadyArbIc stays 0.
- Simultaneous requests after reset: both petitions high. Required:
  - TLB granted first (serviceReadyArbTlb at cycle 11).
  - IC granted in IDLE at cycle 12, serviceReadyArbIc at cycle 23.
  - Third contested round grants TLB again.
- Data write: weTlbArb=1, wdataTlbArb=256'h5A... Required: memWe=1 and memWdata=256'h5A.. during BUSY; serviceReadyArbTlb pulses at cycle 11; rdataArbTlb unchanged.
- Input change mid-transaction: addrIcArb changes to 16'hFFFF and petitionIcArb drops at cycle 4. Required: memAddr keeps its granted value and serviceReadyArbIc still pulses at cycle 11.
- Reset in BUSY: assert reset=0 at cycle 5, asynchronously mid-cycle. Required:
  - memReq falls immediately and all outputs are 0.
  - No serviceReady follows.
  - After release, a held petition is re-granted with the full latency of 11 cycles.
- Back-to-back same side: TLB re-asserts petition on the cycle after its pulse, IC idle. Required: TLB granted again and the new memReq starts one cycle after that IDLE cycle.
